puf_soc_piso: RTL

Parallel-in serial-out transmitter for the PUF SoC serial link. It accepts N_BIT-wide PUF response words on a valid/ready handshake and serializes them LSB-first onto a one-bit valid/ready stream. That stream feeds the downstream SIPO deserializer. A one-word holding register allows back-to-back words with no bubble between them.

---
 rtl/puf_soc_pkg.sv | 27 ++
 rtl/puf_soc_piso_if.sv | 31 +++
 rtl/puf_soc_piso_cnt.sv | 41 ++++
 rtl/puf_soc_piso.sv | 115 +++++++++++
 4 files changed

// File: rtl/puf_soc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_soc_pkg
// Description : Shared types and constants for the PUF SoC serial link blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_soc_pkg;

    // Default word width of the serial link.
    localparam int N_BIT = 32;

    // Width of the bit-index counter for the default word width.
    localparam int CNT_W = $clog2(N_BIT);

    // PISO transmitter states.
    typedef enum logic [0:0] {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_e;

    // Counter width for an arbitrary word width (never narrower than 1 bit).
    function automatic int piso_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : puf_soc_pkg
`default_nettype wire

// File: rtl/puf_soc_piso_if.sv
`default_nettype none
// ============================================================================
// Module      : puf_soc_piso_if
// Description : Parallel-word and serial-bit handshake bundle of the PISO.
//               Signal prefixes are from the transmitter's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface puf_soc_piso_if #(
    parameter int N_BIT = 32
);
    logic             i_par_valid;
    logic [N_BIT-1:0] i_par_data;
    logic             o_par_ready;
    logic             o_ser_valid;
    logic             o_ser_data;
    logic             o_ser_last;
    logic             i_ser_ready;

    // Transmitter side
    modport slave (
        input  i_par_valid, i_par_data, i_ser_ready,
        output o_par_ready, o_ser_valid, o_ser_data, o_ser_last
    );

    // Word producer / bit consumer side
    modport master (
        output i_par_valid, i_par_data, i_ser_ready,
        input  o_par_ready, o_ser_valid, o_ser_data, o_ser_last
    );
endinterface : puf_soc_piso_if
`default_nettype wire

// File: rtl/puf_soc_piso_cnt.sv
`default_nettype none
// ============================================================================
// Module      : puf_soc_piso_cnt
// Description : Bit-index counter with synchronous clear, enable and a
//               terminal-count flag at N_BIT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_soc_piso_cnt
    import puf_soc_pkg::*;
#(
    parameter int N_BIT = 32,
    parameter int CNT_W = piso_cnt_w(N_BIT)
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              i_clr,
    input  wire              i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);
    localparam logic [CNT_W-1:0] c_TC  = CNT_W'(N_BIT - 1);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over enable so a word boundary always restarts at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == c_TC);

endmodule : puf_soc_piso_cnt
`default_nettype wire

// File: rtl/puf_soc_piso.sv
`default_nettype none
// ============================================================================
// Module      : puf_soc_piso
// Description : Parallel-in serial-out transmitter. Words are accepted into a
//               one-deep holding register and shifted out LSB first on a
//               one-bit valid/ready stream, back-to-back without bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_soc_piso
    import puf_soc_pkg::*;
#(
    parameter int N_BIT = 32
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire                   i_flush,
    puf_soc_piso_if.slave         bus,
    output logic                  o_busy
);
    localparam int c_CNT_W = piso_cnt_w(N_BIT);

    piso_state_e        r_state;
    logic [N_BIT-1:0]   r_shreg;
    logic [N_BIT-1:0]   r_hold;
    logic               r_hold_full;
    logic               r_par_ready;

    logic [c_CNT_W-1:0] w_cnt;
    logic               w_tc;
    logic               w_shift;
    logic               w_accept;
    logic               w_ser_hs;
    logic               w_last_hs;
    logic               w_load;

    assign w_shift   = (r_state == PISO_SHIFT);
    assign w_accept  = bus.i_par_valid & r_par_ready;
    assign w_ser_hs  = w_shift & bus.i_ser_ready;
    assign w_last_hs = w_ser_hs & w_tc;
    // Held word moves into the shift register from IDLE or on the last bit.
    assign w_load    = r_hold_full & (~w_shift | w_last_hs);

    puf_soc_piso_cnt #(
        .N_BIT (N_BIT),
        .CNT_W (c_CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (i_flush | w_load | w_last_hs),
        .i_en  (w_ser_hs & ~w_tc),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    // Control FSM, holding register and shift register. o_par_ready is kept
    // in its own flop as the inverse of the hold flag so it has no input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PISO_IDLE;
            r_shreg     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_par_ready <= 1'b1;
        end else if (i_flush) begin
            r_state     <= PISO_IDLE;
            r_shreg     <= '0;
            r_hold_full <= 1'b0;
            r_par_ready <= 1'b1;
        end else begin
            // Accept needs an empty hold, drain needs a full one: never both.
            if (w_accept) begin
                r_hold      <= bus.i_par_data;
                r_hold_full <= 1'b1;
                r_par_ready <= 1'b0;
            end
            case (r_state)
                PISO_IDLE: begin
                    if (r_hold_full) begin
                        r_shreg     <= r_hold;
                        r_hold_full <= 1'b0;
                        r_par_ready <= 1'b1;
                        r_state     <= PISO_SHIFT;
                    end
                end
                PISO_SHIFT: begin
                    if (w_ser_hs) begin
                        if (!w_tc) begin
                            r_shreg <= {1'b0, r_shreg[N_BIT-1:1]};
                        end else if (r_hold_full) begin
                            r_shreg     <= r_hold;
                            r_hold_full <= 1'b0;
                            r_par_ready <= 1'b1;
                        end else begin
                            r_shreg <= {1'b0, r_shreg[N_BIT-1:1]};
                            r_state <= PISO_IDLE;
                        end
                    end
                end
                default: r_state <= PISO_IDLE;
            endcase
        end
    end

    assign bus.o_par_ready = r_par_ready;
    assign bus.o_ser_valid = w_shift;
    assign bus.o_ser_data  = r_shreg[0];
    assign bus.o_ser_last  = w_shift & w_tc;
    assign o_busy          = w_shift | r_hold_full;

    // Index is observable for debug only; the terminal flag drives control.
    logic w_cnt_unused;
    assign w_cnt_unused = ^w_cnt;

endmodule : puf_soc_piso
`default_nettype wire
